mem_port_arbiter: RTL

Shares the core's single memory port between the fetch stage's instruction interface and the load/store data interface. Sits between the fetch stage (instr_req/gnt/rvalid handshake) and the memory: it grants one address phase per cycle, tracks outstanding transactions in an owner FIFO, and routes each response back to the requester that issued it. Fixed data-over-instruction priority plus a starvation counter guarantees forward progress for fetch.

---
 rtl/mem_port_arbiter_if.sv | 48 ++++
 rtl/mem_port_arbiter.sv | 131 +++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the arbiter, the fetch/LSU requesters and the shared memory port.
// The slave modport is the arbiter's view; master is the environment driving it.
interface mem_port_arbiter_if;
    logic        instr_req;
    logic [31:0] instr_addr;
    logic        instr_gnt;
    logic        instr_rvalid;
    logic [31:0] instr_rdata;
    logic        instr_err;

    logic        data_req;
    logic        data_we;
    logic [3:0]  data_be;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_gnt;
    logic        data_rvalid;
    logic [31:0] data_rdata;
    logic        data_err;

    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        mem_err;

    modport slave (
        input  instr_req, instr_addr,
        input  data_req, data_we, data_be, data_addr, data_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata, mem_err,
        output instr_gnt, instr_rvalid, instr_rdata, instr_err,
        output data_gnt, data_rvalid, data_rdata, data_err,
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata
    );

    modport master (
        output instr_req, instr_addr,
        output data_req, data_we, data_be, data_addr, data_wdata,
        output mem_gnt, mem_rvalid, mem_rdata, mem_err,
        input  instr_gnt, instr_rvalid, instr_rdata, instr_err,
        input  data_gnt, data_rvalid, data_rdata, data_err,
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and LSU: data-first priority with a fetch
// starvation escape, owner FIFO for response routing, address-phase lock while stalled.
//
//   state    | meaning
//   LK_FREE  | no stalled address phase, selection follows priority
//   LK_INSTR | fetch address phase presented but not accepted, hold fetch
//   LK_DATA  | LSU address phase presented but not accepted, hold LSU
module mem_port_arbiter #(
    parameter int MAX_OUTSTANDING = 2,
    parameter int STARVE_LIMIT    = 4
) (
    input  logic              clk,
    input  logic              rstn,
    mem_port_arbiter_if.slave bus,
    output logic              busy,
    output logic              spurious
);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] CNT_FULL   = CW'(MAX_OUTSTANDING);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [SW-1:0] STARVE_ONE = SW'(1);

    typedef enum logic [1:0] {
        LK_FREE  = 2'd0,
        LK_INSTR = 2'd1,
        LK_DATA  = 2'd2
    } lock_t;

    lock_t                      lock_q, lock_d;
    logic [MAX_OUTSTANDING-1:0] owner_q, owner_d;
    logic [CW-1:0]              count_q, count_d;
    logic [SW-1:0]              starve_q, starve_d;
    logic                       spurious_q;

    logic sel_data;
    logic sel_req;
    logic full;
    logic push;
    logic pop;
    int   wr_idx;

    always_comb begin
        sel_data = 1'b0;
        case (lock_q)
            LK_INSTR: sel_data = 1'b0;
            LK_DATA:  sel_data = 1'b1;
            default: begin
                if (starve_q == STARVE_MAX && bus.instr_req)
                    sel_data = 1'b0;
                else
                    sel_data = bus.data_req;
            end
        endcase
    end

    // Full is judged on the registered count, so a same-cycle pop does not reopen the port.
    assign full    = (count_q == CNT_FULL);
    assign sel_req = sel_data ? bus.data_req : bus.instr_req;
    assign push    = bus.mem_req & bus.mem_gnt;
    assign pop     = bus.mem_rvalid & (count_q != '0);

    assign bus.mem_req   = sel_req & ~full & rstn;
    assign bus.mem_we    = sel_data & bus.data_we;
    assign bus.mem_be    = sel_data ? bus.data_be : 4'hF;
    assign bus.mem_addr  = sel_data ? bus.data_addr : bus.instr_addr;
    assign bus.mem_wdata = sel_data ? bus.data_wdata : 32'h0;

    assign bus.instr_gnt = push & ~sel_data;
    assign bus.data_gnt  = push & sel_data;

    assign bus.instr_rvalid = pop & ~owner_q[0];
    assign bus.data_rvalid  = pop & owner_q[0];
    assign bus.instr_rdata  = bus.mem_rdata;
    assign bus.data_rdata   = bus.mem_rdata;
    assign bus.instr_err    = bus.mem_err;
    assign bus.data_err     = bus.mem_err;

    assign busy     = (count_q != '0);
    assign spurious = spurious_q;

    // Lock also releases if the held requester withdraws, so the other side cannot deadlock.
    always_comb begin
        lock_d = LK_FREE;
        if (bus.mem_req && !bus.mem_gnt)
            lock_d = sel_data ? LK_DATA : LK_INSTR;
    end

    // Owner FIFO as a shift register with the head at bit 0.
    always_comb begin
        owner_d = owner_q;
        count_d = count_q;
        wr_idx  = int'(count_q) - (pop ? 1 : 0);
        if (pop) begin
            for (int i = 0; i < MAX_OUTSTANDING - 1; i++)
                owner_d[i] = owner_q[i+1];
            owner_d[MAX_OUTSTANDING-1] = 1'b0;
            count_d = count_q - CNT_ONE;
        end
        if (push) begin
            for (int i = 0; i < MAX_OUTSTANDING; i++)
                if (i == wr_idx)
                    owner_d[i] = sel_data;
            count_d = pop ? count_q : count_q + CNT_ONE;
        end
    end

    always_comb begin
        starve_d = '0;
        if (bus.instr_req && !bus.instr_gnt)
            starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + STARVE_ONE;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lock_q     <= LK_FREE;
            owner_q    <= '0;
            count_q    <= '0;
            starve_q   <= '0;
            spurious_q <= 1'b0;
        end else begin
            lock_q   <= lock_d;
            owner_q  <= owner_d;
            count_q  <= count_d;
            starve_q <= starve_d;
            if (bus.mem_rvalid && count_q == '0)
                spurious_q <= 1'b1;
        end
    end
endmodule
